// File: rtl/pulse_train_gen_pkg.sv
// rtl/pulse_train_gen_pkg.sv - shared state encoding and width helper for the pulse train generator
package pulse_train_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  function automatic int pt_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_train_gen_phase_timer.sv
// rtl/pulse_train_gen_phase_timer.sv - loadable down-counter shared by the HIGH and LOW phases
module phase_timer #(
  parameter int TW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          zero
);

  logic [TW-1:0] count;

  // Saturates at zero so an idle timer stays quiet without a separate enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - TW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// rtl/pulse_train_gen.sv - start-triggered train of NUM registered pulses with done strobe and abort
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 4,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num,
  input  logic             abort,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int TW = $clog2(pt_max(HIGH_CYCLES, LOW_CYCLES)) + 1;
  localparam logic [TW-1:0] HIGH_LOAD = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0] LOW_LOAD  = TW'(LOW_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic             tmr_load;
  logic [TW-1:0]    tmr_load_val;
  logic             tmr_zero;
  logic             accept;
  logic             last_pulse;

  assign accept     = start && (num != '0);
  assign last_pulse = (remaining == CNT_W'(1));

  phase_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .zero     (tmr_zero)
  );

  // Loading zero doubles as the timer clear on abort or a stray state.
  always_comb begin
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    if (abort) begin
      tmr_load = 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          tmr_load     = 1'b1;
          tmr_load_val = HIGH_LOAD;
        end
        ST_HIGH: if (tmr_zero) begin
          tmr_load     = 1'b1;
          tmr_load_val = LOW_LOAD;
        end
        ST_LOW: if (tmr_zero && !last_pulse) begin
          tmr_load     = 1'b1;
          tmr_load_val = HIGH_LOAD;
        end
        default: tmr_load = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      state     <= ST_IDLE;
      remaining <= '0;
      out       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_HIGH;
            remaining <= num;
            out       <= 1'b1;
            busy      <= 1'b1;
          end else begin
            out  <= 1'b0;
            busy <= 1'b0;
          end
        end
        ST_HIGH: begin
          if (tmr_zero) begin
            state <= ST_LOW;
            out   <= 1'b0;
          end
        end
        ST_LOW: begin
          if (tmr_zero) begin
            if (last_pulse) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= ST_HIGH;
              remaining <= remaining - CNT_W'(1);
              out       <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          out   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb/tb_pulse_train_gen.sv - directed self-checking bench for pulse_train_gen
module tb_pulse_train_gen;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic [3:0] num;
  logic       out, busy, done;

  logic       f_rst_n, f_start, f_abort;
  logic [7:0] f_num;
  logic       f_out, f_busy, f_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulse_train_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num(num), .abort(abort),
    .out(out), .busy(busy), .done(done)
  );

  pulse_train_gen #(.HIGH_CYCLES(1), .LOW_CYCLES(1), .CNT_W(8)) dut_fast (
    .clk(clk), .rst_n(f_rst_n), .start(f_start), .num(f_num), .abort(f_abort),
    .out(f_out), .busy(f_busy), .done(f_done)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_main(input string tag, input int c, input logic eo, input logic eb, input logic ed);
    check($sformatf("%s out c%0d", tag, c), int'(out), int'(eo));
    check($sformatf("%s busy c%0d", tag, c), int'(busy), int'(eb));
    check($sformatf("%s done c%0d", tag, c), int'(done), int'(ed));
  endtask

  int  edges, dones;
  logic prev;

  initial begin
    rst_n = 1'b0; start = 1'b1; num = 4'd3; abort = 1'b0;
    f_rst_n = 1'b0; f_start = 1'b0; f_num = 8'd0; f_abort = 1'b0;

    // 1: reset held with start asserted
    for (int c = 1; c <= 3; c++) begin
      tick();
      expect_main("reset", c, 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b1; f_rst_n = 1'b1; start = 1'b0;
    tick();
    expect_main("post_reset", 0, 1'b0, 1'b0, 1'b0);

    // 2: num=3
    start = 1'b1; num = 4'd3; edges = 0; prev = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      start = 1'b0;
      expect_main("num3", c,
                  (c >= 1 && c <= 4) || (c >= 9 && c <= 12) || (c >= 17 && c <= 20),
                  (c >= 1 && c <= 24), (c == 25));
      if (out && !prev) edges++;
      prev = out;
    end
    check("num3 edges", edges, 3);

    // 3a: num=0 ignored
    start = 1'b1; num = 4'd0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      start = 1'b0;
      expect_main("num0", c, 1'b0, 1'b0, 1'b0);
    end

    // 3b: start held while busy
    start = 1'b1; num = 4'd2; edges = 0; dones = 0; prev = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (c == 14) start = 1'b0;
      expect_main("held", c,
                  (c >= 1 && c <= 4) || (c >= 9 && c <= 12),
                  (c >= 1 && c <= 16), (c == 17));
      if (out && !prev) edges++;
      if (done) dones++;
      prev = out;
    end
    check("held edges", edges, 2);
    check("held dones", dones, 1);

    // 4a: abort at T+6
    start = 1'b1; num = 4'd2; dones = 0;
    for (int c = 1; c <= 25; c++) begin
      tick();
      start = 1'b0;
      abort = (c == 6);
      expect_main("abort", c, (c >= 1 && c <= 4), (c >= 1 && c <= 6), 1'b0);
      if (done) dones++;
    end
    check("abort dones", dones, 0);

    // 4b: start and abort together in IDLE
    start = 1'b1; abort = 1'b1; num = 4'd3;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start = 1'b0; abort = 1'b0;
      expect_main("start_abort", c, 1'b0, 1'b0, 1'b0);
    end

    // 5: back-to-back, second start in the done cycle
    start = 1'b1; num = 4'd1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      start = (c == 9);
      expect_main("b2b", c,
                  (c >= 1 && c <= 4) || (c >= 10 && c <= 13),
                  (c >= 1 && c <= 8) || (c >= 10 && c <= 17),
                  (c == 9) || (c == 18));
    end
    start = 1'b0;

    // 6a: H=1 L=1, 255 pulses
    f_start = 1'b1; f_num = 8'd255; edges = 0; dones = 0; prev = 1'b0;
    for (int c = 1; c <= 515; c++) begin
      tick();
      f_start = 1'b0;
      check($sformatf("fast out c%0d", c), int'(f_out), int'((c <= 510) && (c % 2 == 1)));
      check($sformatf("fast busy c%0d", c), int'(f_busy), int'(c <= 510));
      check($sformatf("fast done c%0d", c), int'(f_done), int'(c == 511));
      if (f_out && !prev) edges++;
      prev = f_out;
    end
    check("fast edges", edges, 255);

    // 6b: reset mid-train at T+100
    f_start = 1'b1; f_num = 8'd255; dones = 0;
    for (int c = 1; c <= 130; c++) begin
      tick();
      f_start = 1'b0;
      f_rst_n = !(c == 100);
      if (c <= 100)
        check($sformatf("fast_rst out c%0d", c), int'(f_out), int'(c % 2 == 1));
      else begin
        check($sformatf("fast_rst out c%0d", c), int'(f_out), 0);
        check($sformatf("fast_rst busy c%0d", c), int'(f_busy), 0);
      end
      if (f_done) dones++;
    end
    check("fast_rst dones", dones, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
